// File: rtl/spram_pkg.sv
// Shared types and helpers for the spram read-modify-write initiator.
package spram_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RD    = 2'd1,
    MERGE = 2'd2,
    WR    = 2'd3
  } state_t;

  function automatic int lane_count(input int w);
    return (w + 7) / 8;
  endfunction

  // Expands one lane strobe into the bit mask covering that byte.
  function automatic logic [7:0] lane_mask_byte(input logic en);
    return {8{en}};
  endfunction

endpackage

// File: rtl/spram_lane_merge.sv
// Combinational byte-lane merge: strobed lanes take new_word, the rest keep old_word.
module spram_lane_merge
  import spram_pkg::*;
#(
  parameter  int DATA_WIDTH = 16,
  localparam int LANES      = lane_count(DATA_WIDTH)
) (
  input  logic [DATA_WIDTH-1:0] old_word,
  input  logic [DATA_WIDTH-1:0] new_word,
  input  logic [LANES-1:0]      lane,
  output logic [DATA_WIDTH-1:0] merged
);

  logic [8*LANES-1:0] mask;

  // The top lane may be narrower than a byte; its unused mask bits fall off the slice.
  always_comb begin
    mask = '0;
    for (int i = 0; i < LANES; i++) begin
      mask[8*i +: 8] = lane_mask_byte(lane[i]);
    end
    merged = (new_word & mask[DATA_WIDTH-1:0]) | (old_word & ~mask[DATA_WIDTH-1:0]);
  end

endmodule

// File: rtl/spram_rmw.sv
// Host-side spram initiator; partial-lane writes run as read-modify-write.
// Define SPRAM_NATIVE_LANE_EN when the RAM honours lane enables natively.
module spram_rmw
  import spram_pkg::*;
#(
  parameter  int ADDR_WIDTH = 10,
  parameter  int DATA_WIDTH = 16,
  localparam int LANES      = lane_count(DATA_WIDTH)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  h_valid,
  output logic                  h_ready,
  input  logic                  h_we,
  input  logic                  h_re,
  input  logic [ADDR_WIDTH-1:0] h_addr,
  input  logic [DATA_WIDTH-1:0] h_wdata,
  input  logic [LANES-1:0]      h_lane,
  output logic [DATA_WIDTH-1:0] h_rdata,
  output logic                  h_rvalid,
  output logic [ADDR_WIDTH-1:0] m_addr,
  output logic [DATA_WIDTH-1:0] m_din,
  input  logic [DATA_WIDTH-1:0] m_dout,
  output logic                  m_we,
  output logic                  m_re,
  output logic [LANES-1:0]      m_lane
);

`ifdef SPRAM_NATIVE_LANE_EN
  localparam bit NATIVE_LANE = 1'b1;
`else
  localparam bit NATIVE_LANE = 1'b0;
`endif

  localparam logic [LANES-1:0] ALL_LANES = '1;

  state_t                state;
  logic                  rd_p0;
  logic [DATA_WIDTH-1:0] wdata_p0;
  logic [LANES-1:0]      lane_p0;
  logic [DATA_WIDTH-1:0] merged;
  logic                  direct_wr;
  logic                  accept;

  assign h_ready   = (state == IDLE);
  assign accept    = h_valid && h_ready;
  assign direct_wr = (h_lane == ALL_LANES) || (NATIVE_LANE && (h_lane != '0));

  spram_lane_merge #(
    .DATA_WIDTH (DATA_WIDTH)
  ) u_merge (
    .old_word (m_dout),
    .new_word (wdata_p0),
    .lane     (lane_p0),
    .merged   (merged)
  );

  // Acceptance stage: host data is captured once and held for the merge.
  always_ff @(posedge clk) begin
    if (accept) begin
      wdata_p0 <= h_wdata;
      lane_p0  <= h_lane;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= IDLE;
      rd_p0    <= 1'b0;
      h_rdata  <= '0;
      h_rvalid <= 1'b0;
      m_addr   <= '0;
      m_din    <= '0;
      m_we     <= 1'b0;
      m_re     <= 1'b0;
      m_lane   <= '0;
    end else begin
      h_rvalid <= 1'b0;
      m_we     <= 1'b0;
      m_re     <= 1'b0;
      m_lane   <= '0;
      case (state)
        IDLE: begin
          if (accept) begin
            if (h_we) begin
              if (direct_wr) begin
                state  <= WR;
                m_we   <= 1'b1;
                m_addr <= h_addr;
                m_din  <= h_wdata;
                m_lane <= NATIVE_LANE ? h_lane : ALL_LANES;
              end else if (h_lane != '0) begin
                state  <= RD;
                rd_p0  <= 1'b0;
                m_re   <= 1'b1;
                m_addr <= h_addr;
              end
            end else if (h_re) begin
              state  <= RD;
              rd_p0  <= 1'b1;
              m_re   <= 1'b1;
              m_addr <= h_addr;
            end
          end
        end
        RD: state <= MERGE;
        // Merge stage: m_dout now holds the word fetched in RD.
        MERGE: begin
          if (rd_p0) begin
            h_rdata  <= m_dout;
            h_rvalid <= 1'b1;
            state    <= IDLE;
          end else begin
            m_din  <= merged;
            m_we   <= 1'b1;
            m_lane <= ALL_LANES;
            state  <= WR;
          end
        end
        WR:      state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_spram_rmw.sv
// Randomized bench for spram_rmw with a behavioural RAM and a word-level reference memory.
module tb_spram_rmw;
  localparam int AW = 10;
  localparam int DW = 16;
  localparam int LN = 2;
`ifdef SPRAM_NATIVE_LANE_EN
  localparam bit NATIVE = 1'b1;
`else
  localparam bit NATIVE = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          h_valid = 1'b0, h_we = 1'b0, h_re = 1'b0;
  logic [AW-1:0] h_addr = '0;
  logic [DW-1:0] h_wdata = '0;
  logic [LN-1:0] h_lane = '0;
  logic          h_ready, h_rvalid, m_we, m_re;
  logic [DW-1:0] h_rdata, m_din;
  logic [DW-1:0] m_dout = '0;
  logic [AW-1:0] m_addr;
  logic [LN-1:0] m_lane;

  logic [DW-1:0] mem     [0:1023];
  logic [DW-1:0] ref_mem [0:1023];
  logic [DW-1:0] last_rdata;

  int checks = 0, errors = 0;
  int overlap = 0, lane_bad = 0, we_pulses = 0, exp_writes = 0;

  logic [DW-1:0] u_old, u_new, u_out;
  logic [LN-1:0] u_lane;

  always #5 clk = ~clk;

  spram_rmw #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
    .clk(clk), .rst_n(rst_n), .h_valid(h_valid), .h_ready(h_ready),
    .h_we(h_we), .h_re(h_re), .h_addr(h_addr), .h_wdata(h_wdata),
    .h_lane(h_lane), .h_rdata(h_rdata), .h_rvalid(h_rvalid),
    .m_addr(m_addr), .m_din(m_din), .m_dout(m_dout), .m_we(m_we),
    .m_re(m_re), .m_lane(m_lane)
  );

  spram_lane_merge #(.DATA_WIDTH(DW)) u_ref (
    .old_word(u_old), .new_word(u_new), .lane(u_lane), .merged(u_out)
  );

  function automatic logic [DW-1:0] lane_bits(input logic [LN-1:0] l);
    logic [DW-1:0] m;
    m = '0;
    for (int i = 0; i < LN; i++) if (l[i]) m = m | (16'h00FF << (8 * i));
    return m;
  endfunction

  function automatic logic [DW-1:0] model_merge(input logic [DW-1:0] o, input logic [DW-1:0] n,
                                                input logic [LN-1:0] l);
    return (n & lane_bits(l)) | (o & ~lane_bits(l));
  endfunction

  // Behavioural single-port RAM with one-cycle read latency.
  always @(posedge clk) begin
    if (m_we) mem[m_addr] <= (mem[m_addr] & ~lane_bits(m_lane)) | (m_din & lane_bits(m_lane));
    if (m_re) m_dout <= mem[m_addr];
  end

  always @(negedge clk) begin
    if (m_we && m_re) overlap++;
    if (m_we) we_pulses++;
    if (!m_we && m_lane != '0) lane_bad++;
    if (!NATIVE && m_we && m_lane != 2'b11) lane_bad++;
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic check_reset_vals(input string tag);
    check_eq({tag, ".h_ready"}, h_ready, 1);
    check_eq({tag, ".h_rvalid"}, h_rvalid, 0);
    check_eq({tag, ".h_rdata"}, h_rdata, 0);
    check_eq({tag, ".m_we"}, m_we, 0);
    check_eq({tag, ".m_re"}, m_re, 0);
    check_eq({tag, ".m_addr"}, m_addr, 0);
    check_eq({tag, ".m_din"}, m_din, 0);
    check_eq({tag, ".m_lane"}, m_lane, 0);
  endtask

  task automatic do_req(input string tag, input bit we, input bit re, input logic [AW-1:0] a,
                        input logic [DW-1:0] d, input logic [LN-1:0] l);
    int re_k, we_k, rv_k, rdy_k, re_n, we_n, rv_n;
    int exp_re, exp_we, exp_rv, exp_rdy;
    logic [DW-1:0] exp_din, din_at, exp_rdata;
    logic [AW-1:0] addr_re, addr_we;
    logic [LN-1:0] lane_at, exp_lane;
    exp_re = 0; exp_we = 0; exp_rv = 0; exp_rdy = 1;
    exp_din = '0; exp_lane = NATIVE ? l : 2'b11;
    exp_rdata = last_rdata;
    if (we) begin
      if (l != '0) begin
        if (NATIVE || l == 2'b11) begin
          exp_we = 1; exp_rdy = 2; exp_din = d;
        end else begin
          exp_re = 1; exp_we = 3; exp_rdy = 4; exp_din = model_merge(ref_mem[a], d, l);
        end
        ref_mem[a] = model_merge(ref_mem[a], d, l);
        exp_writes++;
      end
    end else if (re) begin
      exp_re = 1; exp_rv = 3; exp_rdy = 3; exp_rdata = ref_mem[a];
    end

    check_eq({tag, ".ready_at_T"}, h_ready, 1);
    h_valid = 1'b1; h_we = we; h_re = re; h_addr = a; h_wdata = d; h_lane = l;
    @(posedge clk); #1;
    // Busy cycles: scramble host inputs, which must be ignored.
    h_valid = 1'($urandom); h_we = 1'($urandom); h_re = 1'($urandom);
    h_addr = AW'($urandom); h_wdata = DW'($urandom); h_lane = LN'($urandom);

    re_k = 0; we_k = 0; rv_k = 0; rdy_k = 0; re_n = 0; we_n = 0; rv_n = 0;
    din_at = '0; addr_re = '0; addr_we = '0; lane_at = '0;
    for (int k = 1; k <= 8; k++) begin
      if (m_re) begin re_n++; re_k = k; addr_re = m_addr; end
      if (m_we) begin we_n++; we_k = k; din_at = m_din; addr_we = m_addr; lane_at = m_lane; end
      if (h_rvalid) begin rv_n++; rv_k = k; end
      if (h_ready) begin rdy_k = k; break; end
      @(posedge clk); #1;
    end
    h_valid = 1'b0;

    check_eq({tag, ".ready_cycle"}, rdy_k, exp_rdy);
    check_eq({tag, ".re_count"}, re_n, exp_re != 0 ? 1 : 0);
    check_eq({tag, ".we_count"}, we_n, exp_we != 0 ? 1 : 0);
    check_eq({tag, ".rvalid_count"}, rv_n, exp_rv != 0 ? 1 : 0);
    if (exp_re != 0) begin
      check_eq({tag, ".re_cycle"}, re_k, exp_re);
      check_eq({tag, ".re_addr"}, addr_re, a);
    end
    if (exp_we != 0) begin
      check_eq({tag, ".we_cycle"}, we_k, exp_we);
      check_eq({tag, ".we_addr"}, addr_we, a);
      check_eq({tag, ".we_din"}, din_at, exp_din);
      check_eq({tag, ".we_lane"}, lane_at, exp_lane);
    end
    if (exp_rv != 0) check_eq({tag, ".rvalid_cycle"}, rv_k, exp_rv);
    check_eq({tag, ".rdata"}, h_rdata, exp_rdata);
    last_rdata = exp_rdata;
  endtask

  initial begin
    logic seen_we;
    logic [DW-1:0] b_data, b_exp0, b_exp1;
    logic [DW-1:0] rd [0:1];
    int acc [0:2];
    int idx, cyc, nrd;

    for (int i = 0; i < 1024; i++) begin
      mem[i] = '0;
      ref_mem[i] = '0;
    end
    last_rdata = '0;

    repeat (3) @(posedge clk);
    #1;
    check_reset_vals("reset");
    rst_n = 1'b1;
    @(posedge clk); #1;

    for (int i = 0; i < 8; i++) begin
      u_old = DW'($urandom); u_new = DW'($urandom); u_lane = LN'(i);
      #1;
      check_eq("merge_unit", u_out, model_merge(u_old, u_new, u_lane));
    end

    do_req("full_wr", 1'b1, 1'b0, 10'h005, 16'hBEEF, 2'b11);
    do_req("rd_beef", 1'b0, 1'b1, 10'h005, 16'h0000, 2'b00);
    check_eq("rd_beef.value", h_rdata, 16'hBEEF);
    do_req("part_wr", 1'b1, 1'b0, 10'h005, 16'h1234, 2'b01);
    do_req("rd_be34", 1'b0, 1'b1, 10'h005, 16'h0000, 2'b00);
    check_eq("rd_be34.value", h_rdata, 16'hBE34);
    do_req("lane00", 1'b1, 1'b0, 10'h006, 16'h5555, 2'b00);
    do_req("nop", 1'b0, 1'b0, 10'h006, 16'h5555, 2'b11);
    do_req("we_and_re", 1'b1, 1'b1, 10'h006, 16'h00AA, 2'b11);

    // Reset lands in the MERGE cycle of a partial write.
    do_req("restore", 1'b1, 1'b0, 10'h005, 16'hBEEF, 2'b11);
    h_valid = 1'b1; h_we = 1'b1; h_re = 1'b0; h_addr = 10'h005; h_wdata = 16'h1234; h_lane = 2'b01;
    @(posedge clk); #1;
    h_valid = 1'b0;
    seen_we = m_we;
    check_eq("abort.m_re_T1", m_re, NATIVE ? 0 : 1);
    @(posedge clk); #1;
    seen_we = seen_we | m_we;
    rst_n = 1'b0;
    @(posedge clk); #1;
    seen_we = seen_we | m_we;
    check_reset_vals("abort");
    if (!NATIVE) check_eq("abort.no_we", seen_we, 0);
    else begin
      ref_mem[5] = model_merge(ref_mem[5], 16'h1234, 2'b01);
      exp_writes++;
    end
    rst_n = 1'b1;
    last_rdata = '0;
    @(posedge clk); #1;
    do_req("abort_rd", 1'b0, 1'b1, 10'h005, 16'h0000, 2'b00);
    if (!NATIVE) check_eq("abort_rd.value", h_rdata, 16'hBEEF);

    do_req("lane10", 1'b1, 1'b0, 10'h007, 16'h5600, 2'b10);

    // Streamed read, partial write, read with h_valid held high.
    b_data = DW'($urandom);
    b_exp0 = ref_mem[16];
    b_exp1 = model_merge(ref_mem[16], b_data, 2'b10);
    ref_mem[16] = b_exp1;
    exp_writes++;
    acc[0] = -1; acc[1] = -1; acc[2] = -1;
    rd[0] = '0; rd[1] = '0;
    idx = 0; cyc = 0; nrd = 0;
    while (cyc < 20) begin
      if (h_rvalid) begin
        if (nrd < 2) rd[nrd] = h_rdata;
        nrd++;
      end
      if (idx < 3) begin
        h_valid = 1'b1; h_addr = 10'h010; h_wdata = b_data; h_lane = 2'b10;
        h_we = (idx == 1); h_re = (idx != 1);
        if (h_ready) begin
          acc[idx] = cyc;
          idx++;
        end
      end else begin
        h_valid = 1'b0;
      end
      @(posedge clk); #1;
      cyc++;
    end
    check_eq("b2b.acc0", acc[0], 0);
    check_eq("b2b.acc1", acc[1], 3);
    check_eq("b2b.acc2", acc[2], NATIVE ? 5 : 7);
    check_eq("b2b.nrd", nrd, 2);
    check_eq("b2b.rd0", rd[0], b_exp0);
    check_eq("b2b.rd1", rd[1], b_exp1);
    last_rdata = b_exp1;

    for (int n = 0; n < 80; n++) begin
      do_req("rand", 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
             AW'($urandom_range(0, 7)), DW'($urandom), LN'($urandom_range(0, 3)));
    end

    check_eq("we_re_overlap", overlap, 0);
    check_eq("lane_rule", lane_bad, 0);
    check_eq("write_count", we_pulses, exp_writes);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/spram_rmw.md
# spram_rmw

Host-side initiator for the generic single-port synchronous RAM (`spram`). Accepts word reads and byte-lane writes from the CPU/data bus over a valid/ready handshake and drives the RAM's addr/din/we/re/lane pins. Partial-lane writes such as `c!` and `w!` are carried out as a read-modify-write sequence, so the RAM itself needs no lane enables. Sits between the core's data-memory port and one `spram` instance.

## Interface
- ADDR_WIDTH, 10, word address width, matches RAM
- DATA_WIDTH, 16, word width, matches RAM
- LANES, (DATA_WIDTH+7)/8, derived; lane count, not overridable
- clk  in  1  rising-edge clock
- rst_n  in  1  reset, synchronous, active-low
- h_valid  in  1  host request valid
- h_ready  out  1  block idle, request accepted when h_valid & h_ready
- h_we  in  1  write request; has priority over h_re
- h_re  in  1  read request
- h_addr  in  ADDR_WIDTH  word address
- h_wdata  in  DATA_WIDTH  write data
- h_lane  in  LANES  byte-lane write strobes
- h_rdata  out  DATA_WIDTH  read data, registered
- h_rvalid  out  1  one-cycle pulse, h_rdata valid
- m_addr  out  ADDR_WIDTH  RAM address
- m_din  out  DATA_WIDTH  RAM write data
- m_dout  in  DATA_WIDTH  RAM read data, valid the cycle after m_re
- m_we  out  1  RAM write enable
- m_re  out  1  RAM read enable
- m_lane  out  LANES  RAM lane enables

## Operation
- All outputs are registered except h_ready, which is decoded from state: h_ready = (state == IDLE).
- States: IDLE, RD, MERGE, WR.
- Accepted request with h_we=0, h_re=0: no-op, stays IDLE.
- Accepted request with h_we=1, h_lane=0: no-op, no RAM access, stays IDLE.
- Accepted request with h_we=1, h_lane all ones: IDLE→WR with m_we=1, m_din=h_wdata.
- Accepted partial write: IDLE→RD (m_re=1)→MERGE→WR (m_we=1)→IDLE.
  - In MERGE, m_din is loaded with the merged word: lane i takes h_wdata bits [8i+7:8i], otherwise m_dout.
  - The top lane covers only bits [DATA_WIDTH-1:8(LANES-1)].
- Accepted read (h_we=0, h_re=1): IDLE→RD (m_re=1)→MERGE. In MERGE, h_rdata<=m_dout, h_rvalid<=1. Then →IDLE.
- Address, wdata and lane are latched at acceptance. Host inputs are ignored while h_ready=0.
- m_we and m_re are never high together. m_lane is all ones whenever m_we=1, and 0 otherwise.
- Reset values: state IDLE, h_ready 1, h_rvalid 0, h_rdata 0, m_we 0, m_re 0, m_addr 0, m_din 0, m_lane 0.
- Reset mid-sequence aborts the sequence. A WR not yet reached is never issued, and no partial word is written.

## Timing
- T = acceptance cycle.
- Full write: m_we high in T+1. h_ready high in T+2.
- Read: m_re high in T+1. h_rvalid high and h_rdata valid in T+3, which is also the cycle h_ready returns. h_rdata holds until the next read.
- Partial write: m_re in T+1, m_we in T+3, h_ready in T+4.
- Throughput: one full write per 2 cycles, one read per 3 cycles, one partial write per 4 cycles.

## Configuration
- SPRAM_NATIVE_LANE_EN defined: the RAM honours lane enables. Every write with h_lane≠0 takes the full-write path: m_we in T+1, m_lane=h_lane, m_din=h_wdata. The MERGE path is used for reads only.
- SPRAM_NATIVE_LANE_EN undefined: behaviour as described in Operation, using read-modify-write.

## Structure
- Package spram_pkg holds:
  - the state enum (IDLE, RD, MERGE, WR)
  - the lane-count function (w+7)/8
  - the lane-to-bit-mask expansion function
- One sub-module: spram_lane_merge. It is combinational and takes old word, new word and lane strobes, returning the merged word. The testbench reuses it as the scoreboard reference model.

## Test plan
- DATA_WIDTH=16, ADDR_WIDTH=10, `spram` attached as the RAM.
- Full write then read: write 0xBEEF to 0x005 with lane 11 → m_we in T+1 with m_din 0xBEEF. Read 0x005 → h_rvalid in T+3 with h_rdata 0xBEEF.
- Partial write: with mem[0x005]=0xBEEF, write 0x1234 with lane 01 → m_re in T+1, m_we in T+3 with m_din 0xBE34. Readback gives 0xBE34.
- Degenerate requests: write with lane 00 → no m_re or m_we, h_ready stays 1. Request with h_we=1 and h_re=1, lane 11, data 0x00AA → write performed, no h_rvalid pulse.
- Reset mid-sequence: rst_n=0 in T+2 of the partial write above → m_we never asserted, mem[0x005] remains 0xBEEF, all outputs at reset values in T+3.
- Back-to-back: read, partial write and read streamed with h_valid held high → acceptances in cycles 0, 3 and 7. No overlap of m_we with m_re.
- With SPRAM_NATIVE_LANE_EN defined: write 0x5600 with lane 10 → m_we in T+1, m_lane 10, no m_re, h_ready in T+2.
